// File: rtl/rob_multi_commit.sv
// ----------------------------------------------------------------------------
// rob_multi_commit
//
// Parametrised reorder buffer. Issue allocates up to ALLOC_W entries per cycle
// in program order at the tail. Execute marks entries complete through
// EX_PORTS ticketed completion ports. Up to COMMIT_W completed entries retire
// per cycle from the head towards the ARF / free list. An excepting head entry
// is reported on exc_* and flushes the whole buffer at the edge. flush_i kills
// everything from outside.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   flush_i         kill all entries (mispredict recovery)
//   alloc_*         allocation lanes (valid / dest / lreg / preg / ppreg / pc)
//   alloc_ready     room for ALLOC_W entries and no flush or exception now
//   alloc_ticket    ticket of lane i = (tail + i) mod ROB_ENTRIES
//   ex_*            completion ports (valid / ticket / exception / cause)
//   commit_*        retiring lanes, prefix-contiguous from lane 0
//   exc_valid/cause/pc  head entry retires with an exception
//   count           number of occupied entries
// ----------------------------------------------------------------------------
module rob_multi_commit #(
    parameter int ROB_ENTRIES    = 16,
    parameter int ALLOC_W        = 2,
    parameter int COMMIT_W       = 2,
    parameter int EX_PORTS       = 4,
    parameter int ROB_INDEX_BITS = $clog2(ROB_ENTRIES)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               flush_i,
    input  logic [ALLOC_W-1:0]                 alloc_valid,
    input  logic [ALLOC_W-1:0]                 alloc_dest,
    input  logic [ALLOC_W*6-1:0]               alloc_lreg,
    input  logic [ALLOC_W*6-1:0]               alloc_preg,
    input  logic [ALLOC_W*6-1:0]               alloc_ppreg,
    input  logic [ALLOC_W*32-1:0]              alloc_pc,
    output logic                               alloc_ready,
    output logic [ALLOC_W*ROB_INDEX_BITS-1:0]  alloc_ticket,
    input  logic [EX_PORTS-1:0]                ex_valid,
    input  logic [EX_PORTS*ROB_INDEX_BITS-1:0] ex_ticket,
    input  logic [EX_PORTS-1:0]                ex_exception,
    input  logic [EX_PORTS*4-1:0]              ex_cause,
    output logic [COMMIT_W-1:0]                commit_valid,
    output logic [COMMIT_W-1:0]                commit_write,
    output logic [COMMIT_W*6-1:0]              commit_ldst,
    output logic [COMMIT_W*6-1:0]              commit_pdst,
    output logic [COMMIT_W*6-1:0]              commit_ppdst,
    output logic [COMMIT_W*32-1:0]             commit_pc,
    output logic                               exc_valid,
    output logic [3:0]                         exc_cause,
    output logic [31:0]                        exc_pc,
    output logic [ROB_INDEX_BITS:0]            count
);

    localparam int IDX = ROB_INDEX_BITS;
    localparam int CW  = IDX + 1;

    // ------------------------------------------------------------------
    // Entry storage and pointers
    // ------------------------------------------------------------------
    logic [ROB_ENTRIES-1:0] valid_q,   valid_d;
    logic [ROB_ENTRIES-1:0] pending_q, pending_d;
    logic [ROB_ENTRIES-1:0] exc_q,     exc_d;
    logic [ROB_ENTRIES-1:0] dest_q,    dest_d;
    logic [3:0]             cause_q [ROB_ENTRIES];
    logic [3:0]             cause_d [ROB_ENTRIES];
    logic [5:0]             lreg_q  [ROB_ENTRIES];
    logic [5:0]             lreg_d  [ROB_ENTRIES];
    logic [5:0]             preg_q  [ROB_ENTRIES];
    logic [5:0]             preg_d  [ROB_ENTRIES];
    logic [5:0]             ppreg_q [ROB_ENTRIES];
    logic [5:0]             ppreg_d [ROB_ENTRIES];
    logic [31:0]            pc_q    [ROB_ENTRIES];
    logic [31:0]            pc_d    [ROB_ENTRIES];

    logic [IDX-1:0] head_q,  head_d;
    logic [IDX-1:0] tail_q,  tail_d;
    logic [CW-1:0]  count_q, count_d;

    // ------------------------------------------------------------------
    // Slot addressing per lane
    // ------------------------------------------------------------------
    logic [IDX-1:0] alloc_slot  [ALLOC_W];
    logic [IDX-1:0] commit_slot [COMMIT_W];

    for (genvar gi = 0; gi < ALLOC_W; gi++) begin : g_alloc_slot
        assign alloc_slot[gi]                 = tail_q + IDX'(gi);
        assign alloc_ticket[gi*IDX +: IDX]    = alloc_slot[gi];
    end

    for (genvar gi = 0; gi < COMMIT_W; gi++) begin : g_commit_slot
        assign commit_slot[gi] = head_q + IDX'(gi);
    end

    // ------------------------------------------------------------------
    // Exception at the head, allocation acceptance
    // ------------------------------------------------------------------
    logic exc_fire;
    logic alloc_fire;
    logic [CW-1:0] n_alloc;
    logic [CW-1:0] n_alloc_eff;

    // flush_i masks the exception so an external kill always wins.
    assign exc_fire = !flush_i && (count_q != '0) && valid_q[head_q]
                      && !pending_q[head_q] && exc_q[head_q];

    // Uses the current occupancy only; slots freed by this cycle's commits
    // become usable next cycle.
    assign alloc_ready = (count_q <= CW'(ROB_ENTRIES - ALLOC_W)) && !exc_fire && !flush_i;
    assign alloc_fire  = alloc_ready && alloc_valid[0];

    always_comb begin
        n_alloc = '0;
        for (int i = 0; i < ALLOC_W; i++) begin
            if (alloc_valid[i]) begin
                n_alloc = n_alloc + CW'(1);
            end
        end
    end

    assign n_alloc_eff = alloc_fire ? n_alloc : '0;

    // ------------------------------------------------------------------
    // Completion decode: per entry, any hit plus the exception cause from
    // the lowest-numbered excepting port (scan high to low so low wins).
    // ------------------------------------------------------------------
    logic [ROB_ENTRIES-1:0] ex_hit;
    logic [ROB_ENTRIES-1:0] ex_exc_hit;
    logic [3:0]             ex_cause_sel [ROB_ENTRIES];

    always_comb begin
        for (int e = 0; e < ROB_ENTRIES; e++) begin
            ex_hit[e]       = 1'b0;
            ex_exc_hit[e]   = 1'b0;
            ex_cause_sel[e] = '0;
            for (int p = EX_PORTS - 1; p >= 0; p--) begin
                if (ex_valid[p] && valid_q[e] && (ex_ticket[p*IDX +: IDX] == IDX'(e))) begin
                    ex_hit[e] = 1'b1;
                    if (ex_exception[p]) begin
                        ex_exc_hit[e]   = 1'b1;
                        ex_cause_sel[e] = ex_cause[p*4 +: 4];
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Commit selection: a lane retires only if every older lane does, so
    // the first pending or excepting entry blocks all younger ones.
    // ------------------------------------------------------------------
    logic [COMMIT_W-1:0] commit_ok;
    logic [CW-1:0]       n_commit;
    logic                commit_run;

    always_comb begin
        commit_ok  = '0;
        n_commit   = '0;
        commit_run = !flush_i;
        for (int k = 0; k < COMMIT_W; k++) begin
            if (commit_run && (CW'(k) < count_q) && valid_q[commit_slot[k]]
                && !pending_q[commit_slot[k]] && !exc_q[commit_slot[k]]) begin
                commit_ok[k] = 1'b1;
                n_commit     = n_commit + CW'(1);
            end else begin
                commit_run = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state
    // ------------------------------------------------------------------
    always_comb begin
        valid_d   = valid_q;
        pending_d = pending_q;
        exc_d     = exc_q;
        dest_d    = dest_q;
        cause_d   = cause_q;
        lreg_d    = lreg_q;
        preg_d    = preg_q;
        ppreg_d   = ppreg_q;
        pc_d      = pc_q;
        head_d    = head_q + IDX'(n_commit);
        tail_d    = tail_q + IDX'(n_alloc_eff);
        count_d   = count_q + n_alloc_eff - n_commit;

        for (int e = 0; e < ROB_ENTRIES; e++) begin
            if (ex_hit[e]) begin
                pending_d[e] = 1'b0;
                if (ex_exc_hit[e]) begin
                    exc_d[e]   = 1'b1;
                    cause_d[e] = ex_cause_sel[e];
                end
            end
        end

        for (int k = 0; k < COMMIT_W; k++) begin
            if (commit_ok[k]) begin
                valid_d[commit_slot[k]] = 1'b0;
            end
        end

        // Allocation last: a freshly written slot always starts pending.
        for (int i = 0; i < ALLOC_W; i++) begin
            if (alloc_fire && alloc_valid[i]) begin
                valid_d[alloc_slot[i]]   = 1'b1;
                pending_d[alloc_slot[i]] = 1'b1;
                exc_d[alloc_slot[i]]     = 1'b0;
                cause_d[alloc_slot[i]]   = '0;
                dest_d[alloc_slot[i]]    = alloc_dest[i];
                lreg_d[alloc_slot[i]]    = alloc_lreg[i*6 +: 6];
                preg_d[alloc_slot[i]]    = alloc_preg[i*6 +: 6];
                ppreg_d[alloc_slot[i]]   = alloc_ppreg[i*6 +: 6];
                pc_d[alloc_slot[i]]      = alloc_pc[i*32 +: 32];
            end
        end

        // Exception retirement or external kill empties the buffer and
        // discards everything else that happened this cycle.
        if (flush_i || exc_fire) begin
            valid_d   = '0;
            pending_d = '0;
            exc_d     = '0;
            head_d    = '0;
            tail_d    = '0;
            count_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= '0;
            pending_q <= '0;
            exc_q     <= '0;
            dest_q    <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            for (int e = 0; e < ROB_ENTRIES; e++) begin
                cause_q[e] <= '0;
                lreg_q[e]  <= '0;
                preg_q[e]  <= '0;
                ppreg_q[e] <= '0;
                pc_q[e]    <= '0;
            end
        end else begin
            valid_q   <= valid_d;
            pending_q <= pending_d;
            exc_q     <= exc_d;
            dest_q    <= dest_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            cause_q   <= cause_d;
            lreg_q    <= lreg_d;
            preg_q    <= preg_d;
            ppreg_q   <= ppreg_d;
            pc_q      <= pc_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: payloads are zeroed on lanes that do not retire
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < COMMIT_W; gi++) begin : g_commit_out
        assign commit_valid[gi]         = commit_ok[gi];
        assign commit_write[gi]         = commit_ok[gi] & dest_q[commit_slot[gi]];
        assign commit_ldst[gi*6 +: 6]   = commit_ok[gi] ? lreg_q[commit_slot[gi]]  : '0;
        assign commit_pdst[gi*6 +: 6]   = commit_ok[gi] ? preg_q[commit_slot[gi]]  : '0;
        assign commit_ppdst[gi*6 +: 6]  = commit_ok[gi] ? ppreg_q[commit_slot[gi]] : '0;
        assign commit_pc[gi*32 +: 32]   = commit_ok[gi] ? pc_q[commit_slot[gi]]    : '0;
    end

    assign exc_valid = exc_fire;
    assign exc_cause = exc_fire ? cause_q[head_q] : '0;
    assign exc_pc    = exc_fire ? pc_q[head_q]    : '0;
    assign count     = count_q;

endmodule

// File: tb/tb_rob_multi_commit.sv
// ----------------------------------------------------------------------------
// tb_rob_multi_commit
//
// Directed bench for rob_multi_commit (16 entries, 2 alloc, 2 commit, 4 EX).
// Tracks the expected tail and the in-order PC stream; every retiring lane
// is matched against the next expected PC.
// ----------------------------------------------------------------------------
module tb_rob_multi_commit;

    localparam int N  = 16;
    localparam int AW = 2;
    localparam int CWL = 2;
    localparam int EP = 4;
    localparam int IX = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush_i;
    logic [AW-1:0]    alloc_valid;
    logic [AW-1:0]    alloc_dest;
    logic [AW*6-1:0]  alloc_lreg;
    logic [AW*6-1:0]  alloc_preg;
    logic [AW*6-1:0]  alloc_ppreg;
    logic [AW*32-1:0] alloc_pc;
    logic             alloc_ready;
    logic [AW*IX-1:0] alloc_ticket;
    logic [EP-1:0]    ex_valid;
    logic [EP*IX-1:0] ex_ticket;
    logic [EP-1:0]    ex_exception;
    logic [EP*4-1:0]  ex_cause;
    logic [CWL-1:0]   commit_valid;
    logic [CWL-1:0]   commit_write;
    logic [CWL*6-1:0] commit_ldst;
    logic [CWL*6-1:0] commit_pdst;
    logic [CWL*6-1:0] commit_ppdst;
    logic [CWL*32-1:0] commit_pc;
    logic             exc_valid;
    logic [3:0]       exc_cause;
    logic [31:0]      exc_pc;
    logic [IX:0]      count;

    rob_multi_commit #(
        .ROB_ENTRIES(N), .ALLOC_W(AW), .COMMIT_W(CWL), .EX_PORTS(EP)
    ) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .alloc_valid(alloc_valid), .alloc_dest(alloc_dest),
        .alloc_lreg(alloc_lreg), .alloc_preg(alloc_preg),
        .alloc_ppreg(alloc_ppreg), .alloc_pc(alloc_pc),
        .alloc_ready(alloc_ready), .alloc_ticket(alloc_ticket),
        .ex_valid(ex_valid), .ex_ticket(ex_ticket),
        .ex_exception(ex_exception), .ex_cause(ex_cause),
        .commit_valid(commit_valid), .commit_write(commit_write),
        .commit_ldst(commit_ldst), .commit_pdst(commit_pdst),
        .commit_ppdst(commit_ppdst), .commit_pc(commit_pc),
        .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc),
        .count(count)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          tail_m = 0;
    logic [31:0] expq[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        flush_i      = 1'b0;
        alloc_valid  = '0;
        alloc_dest   = '0;
        alloc_lreg   = '0;
        alloc_preg   = '0;
        alloc_ppreg  = '0;
        alloc_pc     = '0;
        ex_valid     = '0;
        ex_ticket    = '0;
        ex_exception = '0;
        ex_cause     = '0;
    endtask

    // Match retiring lanes against the expected PC stream, then advance one
    // clock. Inputs are released after the edge.
    task automatic tick();
        logic [31:0] e;
        #1;
        for (int k = 0; k < CWL; k++) begin
            if (commit_valid[k]) begin
                e = (expq.size() > 0) ? expq.pop_front() : 32'hDEAD_BEEF;
                check("commit_pc_stream", 64'(commit_pc[k*32 +: 32]), 64'(e));
                $display("commit lane%0d pc=%08h", k, commit_pc[k*32 +: 32]);
            end
        end
        @(posedge clk);
        #1;
        clear_inputs();
        #1;
    endtask

    task automatic alloc_drive(input int n, input logic [31:0] pc0, input bit accept);
        int s;
        for (int i = 0; i < n; i++) begin
            s = (tail_m + i) % N;
            alloc_valid[i]            = 1'b1;
            alloc_dest[i]             = 1'b1;
            alloc_lreg[i*6 +: 6]      = 6'(s);
            alloc_preg[i*6 +: 6]      = 6'(32 + s);
            alloc_ppreg[i*6 +: 6]     = 6'(s);
            alloc_pc[i*32 +: 32]      = pc0 + 32'(4 * i);
            check("alloc_ticket", 64'(alloc_ticket[i*IX +: IX]), 64'(s));
        end
        $display("alloc n=%0d pc0=%08h ticket0=%0d accept=%0d", n, pc0, tail_m % N, accept);
        if (accept) begin
            for (int i = 0; i < n; i++) expq.push_back(pc0 + 32'(4 * i));
            tail_m = (tail_m + n) % N;
        end
    endtask

    task automatic ex_drive(input int p, input int t, input bit exc, input int cause);
        ex_valid[p]            = 1'b1;
        ex_ticket[p*IX +: IX]  = 4'(t % N);
        ex_exception[p]        = exc;
        ex_cause[p*4 +: 4]     = 4'(cause);
        $display("ex port%0d ticket=%0d exc=%0d cause=%0d", p, t % N, exc, cause);
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && count != 0; i++) tick();
        check("drain_count", 64'(count), 64'd0);
    endtask

    int base;
    int prev;

    initial begin
        clear_inputs();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;

        // ---------------- Reset state ----------------
        check("rst_count", 64'(count), 64'd0);
        check("rst_alloc_ready", 64'(alloc_ready), 64'd1);
        check("rst_commit_valid", 64'(commit_valid), 64'd0);
        check("rst_exc_valid", 64'(exc_valid), 64'd0);
        check("rst_ticket0", 64'(alloc_ticket[IX-1:0]), 64'd0);
        check("rst_commit_pc", 64'(commit_pc), 64'd0);

        // ---------------- 1: out-of-order completion ----------------
        alloc_drive(2, 32'h100, 1'b1);
        tick();
        check("t1_count", 64'(count), 64'd2);
        check("t1_nocommit_pending", 64'(commit_valid), 64'd0);
        ex_drive(0, 1, 1'b0, 0);
        tick();
        check("t1_nocommit_head_pending", 64'(commit_valid), 64'd0);
        ex_drive(0, 0, 1'b0, 0);
        tick();
        check("t1_commit_valid", 64'(commit_valid), 64'h3);
        check("t1_commit_pc", 64'(commit_pc), {32'h104, 32'h100});
        check("t1_commit_write", 64'(commit_write), 64'h3);
        check("t1_commit_pdst", 64'(commit_pdst), {6'd33, 6'd32});
        check("t1_commit_ldst", 64'(commit_ldst), {6'd1, 6'd0});
        tick();
        check("t1_count_after", 64'(count), 64'd0);
        check("t1_ticket_head2", 64'(alloc_ticket[IX-1:0]), 64'd2);

        // ---------------- 2: full ----------------
        for (int c = 0; c < 8; c++) begin
            check("t2_ready_fill", 64'(alloc_ready), 64'd1);
            alloc_drive(2, 32'h200 + 32'(8 * c), 1'b1);
            tick();
        end
        check("t2_full_count", 64'(count), 64'd16);
        check("t2_full_ready", 64'(alloc_ready), 64'd0);
        alloc_drive(2, 32'hBAD0, 1'b0);
        tick();
        check("t2_full_dropped", 64'(count), 64'd16);
        ex_drive(0, 2, 1'b0, 0);
        tick();
        check("t2_commit_one", 64'(commit_valid), 64'h1);
        tick();
        check("t2_count15", 64'(count), 64'd15);
        check("t2_ready15", 64'(alloc_ready), 64'd0);
        ex_drive(0, 3, 1'b0, 0);
        tick();
        check("t2_commit_two", 64'(commit_valid), 64'h1);
        tick();
        check("t2_count14", 64'(count), 64'd14);
        check("t2_ready14", 64'(alloc_ready), 64'd1);
        for (int j = 0; j < 14; j++) begin
            ex_drive(0, 4 + j, 1'b0, 0);
            tick();
        end
        drain();
        check("t2_no_loss", 64'(expq.size()), 64'd0);

        // ---------------- 3: wrap, steady 2-in/2-out ----------------
        prev = 0;
        for (int c = 0; c < 40; c++) begin
            base = tail_m;
            alloc_drive(2, 32'h1000 + 32'(8 * c), 1'b1);
            if (c > 0) begin
                ex_drive(0, prev, 1'b0, 0);
                ex_drive(1, prev + 1, 1'b0, 0);
            end
            tick();
            prev = base;
        end
        ex_drive(0, prev, 1'b0, 0);
        ex_drive(1, prev + 1, 1'b0, 0);
        tick();
        drain();
        check("t3_no_loss", 64'(expq.size()), 64'd0);

        // ---------------- 4: precise exception ----------------
        base = tail_m;
        alloc_drive(2, 32'h400, 1'b1); tick();
        alloc_drive(2, 32'h408, 1'b1); tick();
        alloc_drive(2, 32'h410, 1'b1); tick();
        check("t4_count6", 64'(count), 64'd6);
        ex_drive(0, base + 0, 1'b0, 0);
        ex_drive(1, base + 1, 1'b0, 0);
        ex_drive(2, base + 2, 1'b0, 0);
        ex_drive(3, base + 3, 1'b1, 2);
        tick();
        check("t4_A_commit", 64'(commit_valid), 64'h3);
        check("t4_A_exc", 64'(exc_valid), 64'd0);
        ex_drive(0, base + 4, 1'b0, 0);
        ex_drive(1, base + 5, 1'b0, 0);
        tick();
        check("t4_B_commit", 64'(commit_valid), 64'h1);
        check("t4_B_exc", 64'(exc_valid), 64'd0);
        check("t4_B_pc", 64'(commit_pc[31:0]), 64'h408);
        tick();
        check("t4_C_exc", 64'(exc_valid), 64'd1);
        check("t4_C_cause", 64'(exc_cause), 64'h2);
        check("t4_C_pc", 64'(exc_pc), 64'h40C);
        check("t4_C_commit", 64'(commit_valid), 64'd0);
        check("t4_C_ready", 64'(alloc_ready), 64'd0);
        tick();
        expq.delete();
        tail_m = 0;
        check("t4_flushed_count", 64'(count), 64'd0);
        check("t4_flushed_ticket", 64'(alloc_ticket[IX-1:0]), 64'd0);
        check("t4_flushed_exc", 64'(exc_valid), 64'd0);
        check("t4_ready_again", 64'(alloc_ready), 64'd1);

        // ---------------- 5: external flush ----------------
        alloc_drive(2, 32'h500, 1'b1); tick();
        ex_drive(0, 0, 1'b0, 0);
        ex_drive(1, 1, 1'b0, 0);
        tick();
        check("t5_pre_commit", 64'(commit_valid), 64'h3);
        flush_i = 1'b1;
        alloc_drive(2, 32'h5A0, 1'b0);
        ex_drive(2, 0, 1'b1, 3);
        #1;
        check("t5_flush_commit", 64'(commit_valid), 64'd0);
        check("t5_flush_ready", 64'(alloc_ready), 64'd0);
        tick();
        expq.delete();
        tail_m = 0;
        check("t5_count", 64'(count), 64'd0);
        check("t5_commit_after", 64'(commit_valid), 64'd0);
        alloc_drive(2, 32'h600, 1'b1);
        tick();
        check("t5_count_realloc", 64'(count), 64'd2);

        // ---------------- 6: multi-port hit, stale hit ----------------
        ex_drive(1, 0, 1'b1, 5);
        ex_drive(3, 0, 1'b1, 7);
        tick();
        check("t6_exc_valid", 64'(exc_valid), 64'd1);
        check("t6_exc_cause", 64'(exc_cause), 64'h5);
        check("t6_exc_pc", 64'(exc_pc), 64'h600);
        tick();
        expq.delete();
        tail_m = 0;
        check("t6_flushed", 64'(count), 64'd0);
        ex_drive(0, 0, 1'b1, 9);
        tick();
        check("t6_stale_count", 64'(count), 64'd0);
        check("t6_stale_exc", 64'(exc_valid), 64'd0);
        alloc_drive(1, 32'h700, 1'b1);
        tick();
        check("t6_one_alloc", 64'(count), 64'd1);
        check("t6_pending", 64'(commit_valid), 64'd0);
        ex_drive(0, 0, 1'b0, 0);
        tick();
        check("t6_commit", 64'(commit_valid), 64'h1);
        check("t6_commit_pc", 64'(commit_pc[31:0]), 64'h700);
        check("t6_no_exc", 64'(exc_valid), 64'd0);
        tick();
        check("t6_empty", 64'(count), 64'd0);

        // ---------------- Reset mid-operation ----------------
        alloc_drive(2, 32'h800, 1'b1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        expq.delete();
        tail_m = 0;
        check("mid_rst_count", 64'(count), 64'd0);
        check("mid_rst_ticket", 64'(alloc_ticket[IX-1:0]), 64'd0);
        check("mid_rst_ready", 64'(alloc_ready), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
